fifo_drain_stream: RTL and testbench
====================================

// Module: fifo_drain_stream
// PURPOSE
//  Downstream stage of fifo_flops: drains the FIFO through its pndng/pop/Dout interface.
//  Re-presents the words as a valid/ready stream with a 2-entry skid buffer, so the
//  consumer sees one word per cycle while it keeps ready high.
//  Counts words delivered and cycles the stream stalled, for bench scoreboarding.
// PARAMETERS
//  bits   32  word width; must equal the bits of the FIFO it drains
//  cnt_w  16  width of the xfer_cnt and stall_cnt counters
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  pndng      in   1      FIFO has a word; Din holds the head word while pndng=1
//  Din        in   bits   FIFO head word (connects to the FIFO Dout)
//  pop        out  1      pops the FIFO head at this rising edge
//  flush      in   1      synchronous: discard buffered words
//  dout       out  bits   stream data
//  dout_valid out  1      dout holds a valid word
//  dout_ready in   1      consumer accepts; transfer = dout_valid & dout_ready
//  xfer_cnt   out  cnt_w  number of completed transfers; wraps modulo 2^cnt_w
//  stall_cnt  out  cnt_w  cycles with dout_valid=1 and dout_ready=0; saturates at all-ones
// BEHAVIOUR
//  - Reset (async, while rst=1):
//    - state=EMPTY; both buffer entries and dout=0.
//    - dout_valid=0; xfer_cnt=0; stall_cnt=0.
//    - pop is forced to 0 while rst=1.
//  - Storage: head register H (drives dout) and skid register S. dout_valid=1 in states ONE and TWO.
//  - Pop rule (combinational): pop = pndng & !rst & !flush & (state!=TWO).
//    The word on Din is captured at the same edge the FIFO pops it.
//  - States (tr = transfer, pp = pop; all transitions on the rising clk edge):
//    - EMPTY:
//      - pp -> ONE, H<=Din; otherwise stay.
//    - ONE:
//      - tr & pp -> ONE, H<=Din (full throughput).
//      - tr & !pp -> EMPTY.
//      - !tr & pp -> TWO, S<=Din.
//      - otherwise stay.
//    - TWO:
//      - tr -> ONE, H<=S.
//      - otherwise stay. pop is 0 in this state.
//  - Ordering: words leave in exactly the order popped; no loss, no duplication.
//  - Latency: a word popped in cycle N is on dout with dout_valid=1 in cycle N+1 if the buffer was empty.
//  - dout is stable while dout_valid=1 and dout_ready=0.
//  - flush:
//    - Next state is EMPTY; H and S are left unchanged.
//    - pop=0 that cycle.
//    - A transfer that coincides with flush still counts.
//  - xfer_cnt += 1 on every transfer. stall_cnt += 1 on each valid & !ready cycle until all-ones.
//  - Reset mid-stream: buffered words are lost. No pop is issued until the cycle after rst falls.
// TESTING
//  1. Reset, pndng=0 -> dout_valid=0, pop=0, xfer_cnt=0, stall_cnt=0.
//  2. FIFO preloaded with 0x11,0x22,0x33, dout_ready=1 held:
//     -> pop high 3 consecutive cycles; dout 0x11,0x22,0x33 on consecutive cycles;
//     -> xfer_cnt=3, stall_cnt=0.
//  3. Words 0xA,0xB pending, dout_ready=0:
//     -> state TWO after 2 pops, then pop=0, dout=0xA held, stall_cnt increments each cycle.
//     -> Raise ready: 0xA then 0xB delivered, then pop resumes.
//  4. Random ready (~50%) with 200 random words:
//     -> output sequence equals input sequence; xfer_cnt=200.
//  5. flush asserted in state TWO with ready=0:
//     -> next cycle dout_valid=0, pop=0 during the flush cycle, xfer_cnt unchanged.
//  6. rst pulsed mid-stream (state ONE):
//     -> dout_valid falls immediately (async); counters=0; first pop after rst deasserts.

Source files
------------

// File: rtl/fifo_drain_stream.sv
// fifo_drain_stream
//   Drains a pndng/pop/Din FIFO interface and re-presents the words as a
//   valid/ready stream. A head register (H) drives dout and a skid register (S)
//   absorbs the word popped while the consumer stalls. This sustains one word
//   per cycle while dout_ready stays high. It also counts completed transfers
//   and stalled cycles.
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   pndng, Din      FIFO has a word / FIFO head word
//   pop             pops the FIFO head at this rising edge
//   flush           synchronous discard of buffered words
//   dout, dout_valid, dout_ready   output stream handshake
//   xfer_cnt        completed transfers, wraps
//   stall_cnt       cycles with dout_valid & !dout_ready, saturates
module fifo_drain_stream #(
  parameter int unsigned bits  = 32,
  parameter int unsigned cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pndng,
  input  logic [bits-1:0]  Din,
  output logic             pop,
  input  logic             flush,
  output logic [bits-1:0]  dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [cnt_w-1:0] xfer_cnt,
  output logic [cnt_w-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           state_q;
  logic [bits-1:0]  h_q;
  logic [bits-1:0]  s_q;
  logic [cnt_w-1:0] xfer_q, xfer_d;
  logic [cnt_w-1:0] stall_q, stall_d;
  logic             xfer;
  logic             stall;

  assign dout_valid = (state_q != EMPTY);
  assign dout       = h_q;
  assign xfer_cnt   = xfer_q;
  assign stall_cnt  = stall_q;

  // No pop while the skid slot is occupied, while flushing, or in reset.
  assign pop   = pndng & ~rst & ~flush & (state_q != TWO);
  assign xfer  = dout_valid & dout_ready;
  assign stall = dout_valid & ~dout_ready;

  always_comb begin
    xfer_d  = xfer_q;
    stall_d = stall_q;
    if (xfer) begin
      xfer_d = xfer_q + cnt_w'(1);
    end
    if (stall && (stall_q != '1)) begin
      stall_d = stall_q + cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      h_q     <= '0;
      s_q     <= '0;
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
      // Flush only retargets the state; H and S keep their stale contents,
      // which are invisible because dout_valid drops with the state.
      if (flush) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (pop) begin
              state_q <= ONE;
              h_q     <= Din;
            end
          end
          ONE: begin
            if (xfer && pop) begin
              h_q <= Din;
            end else if (xfer) begin
              state_q <= EMPTY;
            end else if (pop) begin
              state_q <= TWO;
              s_q     <= Din;
            end
          end
          TWO: begin
            if (xfer) begin
              state_q <= ONE;
              h_q     <= s_q;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_stream.sv
// Bench for fifo_drain_stream. The FIFO source and the drain stage are modelled
// as plain queues: words popped enter an in-flight queue, transfers remove the
// head, flush/reset empty it. Counters are modelled arithmetically.
module tb_fifo_drain_stream;

  localparam int unsigned BITS = 32;
  localparam int unsigned CW   = 8;

  logic            clk;
  logic            rst;
  logic            pndng;
  logic [BITS-1:0] Din;
  logic            pop;
  logic            flush;
  logic [BITS-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [CW-1:0]   xfer_cnt;
  logic [CW-1:0]   stall_cnt;

  fifo_drain_stream #(
    .bits (BITS),
    .cnt_w(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pndng     (pndng),
    .Din       (Din),
    .pop       (pop),
    .flush     (flush),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BITS-1:0] src[$];
  logic [BITS-1:0] bufq[$];
  logic [BITS-1:0] out_log[$];
  logic [CW-1:0]   m_xfer;
  logic [CW-1:0]   m_stall;
  logic            obs_pop;
  int              n_chk;
  int              n_fail;

  // One clock cycle: drive inputs at the falling edge, compare against the
  // queue model before the rising edge, then advance the model.
  task automatic step(input logic rdy, input logic fl);
    logic            exp_pop;
    logic            exp_xfer;
    logic            exp_stall;
    logic [BITS-1:0] din_v;
    pndng      = (src.size() > 0);
    din_v      = pndng ? src[0] : BITS'($urandom);
    Din        = din_v;
    dout_ready = rdy;
    flush      = fl;
    #1;
    exp_pop   = pndng && !fl && (bufq.size() < 2);
    exp_xfer  = (bufq.size() > 0) && rdy;
    exp_stall = (bufq.size() > 0) && !rdy;
    obs_pop   = pop;
    n_chk++;
    if (pop !== exp_pop) begin
      n_fail++;
      $display("FAIL pop: got %b expected %b at %0t", pop, exp_pop, $time);
    end
    n_chk++;
    if (dout_valid !== (bufq.size() > 0)) begin
      n_fail++;
      $display("FAIL dout_valid: got %b expected %b at %0t", dout_valid, bufq.size() > 0, $time);
    end
    if (bufq.size() > 0) begin
      n_chk++;
      if (dout !== bufq[0]) begin
        n_fail++;
        $display("FAIL dout: got %h expected %h at %0t", dout, bufq[0], $time);
      end
    end
    n_chk++;
    if (xfer_cnt !== m_xfer) begin
      n_fail++;
      $display("FAIL xfer_cnt: got %0d expected %0d at %0t", xfer_cnt, m_xfer, $time);
    end
    n_chk++;
    if (stall_cnt !== m_stall) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d expected %0d at %0t", stall_cnt, m_stall, $time);
    end
    @(posedge clk);
    if (exp_xfer) begin
      out_log.push_back(bufq.pop_front());
      m_xfer = m_xfer + 1'b1;
    end
    if (exp_stall && (m_stall != '1)) m_stall = m_stall + 1'b1;
    if (fl) bufq.delete();
    if (exp_pop) begin
      bufq.push_back(din_v);
      void'(src.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; pndng = 1'b1; Din = 32'h5A5A_5A5A; flush = 1'b0; dout_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (dout_valid !== 1'b0 || pop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b pop=%b expected 0/0", dout_valid, pop);
    end
    n_chk++;
    if (xfer_cnt !== '0 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", xfer_cnt, stall_cnt);
    end
    pndng = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_xfer = '0; m_stall = '0;
    step(1'b1, 1'b0);
  endtask

  task automatic test_basic();
    int base;
    src = '{32'h11, 32'h22, 32'h33};
    base = out_log.size();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      if (i < 3) begin
        n_chk++;
        if (obs_pop !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_pop_run: cycle %0d got %b expected 1", i, obs_pop);
        end
      end
      if (i >= 1 && i <= 3) begin
        n_chk++;
        if (out_log.size() != base + i) begin
          n_fail++;
          $display("FAIL basic_consecutive: cycle %0d got %0d words expected %0d", i, out_log.size() - base, i);
        end
      end
    end
    n_chk++;
    if (out_log.size() != base + 3 || out_log[base] !== 32'h11 || out_log[base+1] !== 32'h22 || out_log[base+2] !== 32'h33) begin
      n_fail++;
      $display("FAIL basic_order: got %0d words expected 11,22,33", out_log.size() - base);
    end
    n_chk++;
    if (xfer_cnt !== 8'd3 || stall_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_counts: got %0d/%0d expected 3/0", xfer_cnt, stall_cnt);
    end
  endtask

  task automatic test_stall_two();
    logic [CW-1:0] s0;
    int base;
    s0 = m_stall;
    src = '{32'hA, 32'hB};
    base = out_log.size();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    n_chk++;
    if (stall_cnt !== s0 + 8'd4 || dout !== 32'hA || dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL two_hold: got stall=%0d dout=%h expected stall=%0d dout=a", stall_cnt, dout, s0 + 8'd4);
    end
    src.push_back(32'hC);
    step(1'b0, 1'b0);
    n_chk++;
    if (obs_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL two_no_pop: got %b expected 0", obs_pop);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    n_chk++;
    if (out_log.size() != base + 3 || out_log[base] !== 32'hA || out_log[base+1] !== 32'hB || out_log[base+2] !== 32'hC) begin
      n_fail++;
      $display("FAIL two_release: got %0d words expected a,b,c", out_log.size() - base);
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] x0;
    src = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    x0 = m_xfer;
    step(1'b0, 1'b1);
    n_chk++;
    if (obs_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pop: got %b expected 0", obs_pop);
    end
    n_chk++;
    if (dout_valid !== 1'b0 || xfer_cnt !== x0) begin
      n_fail++;
      $display("FAIL flush_empty: got valid=%b xfer=%0d expected 0/%0d", dout_valid, xfer_cnt, x0);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    n_chk++;
    if (xfer_cnt !== x0 + 8'd1 || out_log[out_log.size()-1] !== 32'hC2) begin
      n_fail++;
      $display("FAIL flush_with_xfer: got xfer=%0d expected %0d", xfer_cnt, x0 + 8'd1);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
  endtask

  task automatic test_reset_midstream();
    src = '{32'hD0, 32'hD1};
    step(1'b0, 1'b0);
    pndng = 1'b1; Din = src[0]; dout_ready = 1'b0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (dout_valid !== 1'b0 || pop !== 1'b0 || xfer_cnt !== '0 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got valid=%b pop=%b xfer=%0d stall=%0d expected all 0", dout_valid, pop, xfer_cnt, stall_cnt);
    end
    bufq.delete();
    m_xfer = '0; m_stall = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (pop !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_first_pop: got %b expected 1", pop);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [BITS-1:0] words[$];
    logic [CW-1:0]   x0;
    int base;
    int cyc;
    x0 = m_xfer;
    base = out_log.size();
    for (int i = 0; i < 200; i++) begin
      words.push_back(BITS'($urandom));
      src.push_back(words[i]);
    end
    cyc = 0;
    while (out_log.size() < base + 200 && cyc < 3000) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      cyc++;
    end
    n_chk++;
    if (out_log.size() != base + 200) begin
      n_fail++;
      $display("FAIL random_timeout: got %0d words expected 200", out_log.size() - base);
    end else begin
      for (int i = 0; i < 200; i++) begin
        n_chk++;
        if (out_log[base+i] !== words[i]) begin
          n_fail++;
          $display("FAIL random_order: word %0d got %h expected %h", i, out_log[base+i], words[i]);
        end
      end
    end
    n_chk++;
    if (xfer_cnt !== x0 + 8'd200) begin
      n_fail++;
      $display("FAIL random_count: got %0d expected %0d", xfer_cnt, x0 + 8'd200);
    end
  endtask

  task automatic test_stall_saturate();
    src = '{32'hE0};
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0);
    n_chk++;
    if (stall_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL stall_sat: got %0d expected 255", stall_cnt);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int base;
    base = out_log.size();
    for (int i = 0; i < 80; i++) src.push_back(BITS'($urandom));
    for (int i = 0; i < 81; i++) step(1'b1, 1'b0);
    n_chk++;
    if (out_log.size() != base + 80) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d words in 81 cycles expected 80", out_log.size() - base);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    obs_pop = 1'b0;
    test_reset();
    test_basic();
    test_stall_two();
    test_flush();
    test_reset_midstream();
    test_random();
    test_stall_saturate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
